mem_loader: RTL and testbench
=============================

# mem_loader

Parametrised boot-time program loader that owns the memory port while the core is held in reset. It accepts a word stream over a valid/ready handshake, writes it to a configurable address window, optionally reads the window back and checks a checksum, then releases the core. It sits between the external load interface, the memory, and the core's reset, so the memory can be filled outside chip logic with no test-bench muxing.

## Interface
- `ADDR_WIDTH`, default 16: memory address width.
- `DATA_WIDTH`, default 8: memory word width (matches `REG_WIDTH`).
- `LEN_WIDTH`, default 17: width of the `length` input, so a full `2^ADDR_WIDTH` load is expressible.
- `CHK_WIDTH`, default 16: checksum accumulator width.
- `clk` in 1: loader clock, same phase as the memory clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a load; sampled in IDLE, DONE and ERROR only.
- `base_addr` in ADDR_WIDTH: first address written; captured on `start`.
- `length` in LEN_WIDTH: number of words; captured on `start`.
- `s_valid` in 1: stream word valid.
- `s_data` in DATA_WIDTH: stream word.
- `s_ready` out 1: loader accepts a word this cycle.
- `mem_sel` out 1: 1 means the loader drives the memory port; external mux selects on it.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_din` out DATA_WIDTH: memory write data.
- `mem_we` out 1: memory write enable.
- `mem_dout` in DATA_WIDTH: memory read data, valid one cycle after the address is presented with `mem_we`=0.
- `core_reset_n` out 1: active-low reset to the core.
- `busy` out 1: high in LOAD, VERIFY or CHECK.
- `done` out 1: high in DONE.
- `error` out 1: high in ERROR.

## Operation
- States: IDLE, LOAD, VERIFY, CHECK, DONE, ERROR.
- Reset values: state IDLE, `s_ready`=0, `mem_sel`=1, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `core_reset_n`=0, `busy`=0, `done`=0, `error`=0, word counter=0, both checksums=0.
- All outputs are registered.
- IDLE, DONE or ERROR with `start`=1: capture `base_addr` and `length`, clear the counter and checksums, set `core_reset_n`=0 and `mem_sel`=1.
  - Go to LOAD, or to DONE if `length`=0.
- LOAD: `s_ready`=1.
  - Each beat (`s_valid & s_ready`) registers `mem_addr` = base + count (modulo 2^ADDR_WIDTH, wrap allowed), `mem_din`=`s_data` and `mem_we`=1 for exactly the next cycle.
  - The beat adds zero-extended `s_data` to the write checksum (modulo 2^CHK_WIDTH) and increments count.
  - `s_valid`=0 stalls with no write.
  - On the beat where count reaches `length`-1: `s_ready` drops the next cycle, the counter clears, and the state goes to VERIFY.
- VERIFY: issue one read per cycle at base + count, count 0..`length`-1.
  - Each returned `mem_dout` (one cycle later) is added to the read checksum.
  - After the last issue, wait one cycle for the final data, then go to CHECK.
- CHECK, one cycle: go to DONE if the checksums are equal, else ERROR.
- DONE: `core_reset_n`=1, `mem_sel`=0, `mem_we`=0. The core owns memory.
- ERROR: `core_reset_n` stays 0, `mem_sel` stays 1.
- `start` in DONE or ERROR reloads; `core_reset_n` falls on the cycle after `start`.
- `start` while `busy` is ignored.
- `reset_n` low mid-operation: immediate return to reset values. The partially written memory is not cleaned.

## Timing
- `start` at edge 0: LOAD visible and `s_ready`=1 after edge 1.
- Continuous `s_valid` gives one write per cycle. Beat k's write is presented in the cycle after its accept edge.
- Load plus verify of length L with no stalls, `start` edge to `done`=1: 1 + L + (L + 1) + 1 = 2L + 3 edges.
- `LOADER_VERIFY_EN` undefined: L + 2 edges.
- No simultaneous read and write: the last LOAD write completes before the first VERIFY read.

## Configuration
- `LOADER_VERIFY_EN` defined: VERIFY and CHECK states and both checksum accumulators are built; `error` is functional.
- Undefined: LOAD goes directly to DONE after the last write cycle, `error` is tied to 0, and ERROR is unreachable.

## Test plan
- Reset, then `start` with base=16'h8000, length=4, stream 8'hA9,8'h05,8'h85,8'h10 continuously.
  - Writes occur at 8000-8003, `done`=1 at edge 11, `core_reset_n` rises.
  - Readback by the bench matches.
- Same load with `s_valid` deasserted for 3 cycles between beats 2 and 3: no write is issued during the gaps and `done` arrives 3 cycles later.
- Verify mode with a bench-injected corruption of `mem_dout` during VERIFY: `error`=1, `core_reset_n` remains 0, `done`=0.
- base=16'hFFFE, length=4: writes go to FFFE, FFFF, 0000, 0001.
- length=0: `done`=1 on the edge after `start`, with no `mem_we` pulse.
- `reset_n` asserted mid-LOAD after 2 beats: all outputs return to reset values. A new `start` of length 2 completes normally, and `start` asserted again in DONE drops `core_reset_n` the next cycle.

Source files
------------

// File: rtl/mem_loader.sv
// Boot-time loader: owns the memory port while the core is held in reset, fills a window from a
// valid/ready stream, then releases the core. Define LOADER_VERIFY_EN to add checksum readback verify.
module mem_loader #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 17,
   parameter int CHK_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  length,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  mem_sel,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  core_reset_n,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_VERIFY = 3'd2;
   localparam logic [2:0] S_CHECK  = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;
   localparam logic [2:0] S_ERROR  = 3'd5;
   localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
`ifdef LOADER_VERIFY_EN
   localparam logic [2:0] S_POST_LOAD = S_VERIFY;
`else
   localparam logic [2:0] S_POST_LOAD = S_LOAD;
`endif

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  s_ready_q, s_ready_d;
   logic                  mem_sel_q, mem_sel_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
   logic                  mem_we_q, mem_we_d;
   logic                  core_rst_n_q, core_rst_n_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  beat_s;
   logic [ADDR_WIDTH-1:0] cur_addr_s;
`ifdef LOADER_VERIFY_EN
   logic [CHK_WIDTH-1:0]  wr_sum_q, wr_sum_d;
   logic [CHK_WIDTH-1:0]  rd_sum_q, rd_sum_d;
   logic [CHK_WIDTH-1:0]  rd_sum_next_s;
   logic                  rd_issue_q, rd_issue_d;
   logic                  rd_valid_q, rd_valid_d;
`else
   logic                  unused_dout_s;
   assign unused_dout_s = ^mem_dout;
`endif

   // Next-state, datapath and output decode.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      s_ready_d  = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      mem_we_d   = 1'b0;
      beat_s     = s_valid & s_ready_q;
      cur_addr_s = base_q + cnt_q[ADDR_WIDTH-1:0];
`ifdef LOADER_VERIFY_EN
      wr_sum_d      = wr_sum_q;
      rd_issue_d    = 1'b0;
      rd_valid_d    = rd_issue_q;
      // Read data lands one cycle after its address, so the final word is folded in during CHECK.
      rd_sum_next_s = rd_sum_q + (rd_valid_q ? CHK_WIDTH'(mem_dout) : {CHK_WIDTH{1'b0}});
      rd_sum_d      = rd_sum_next_s;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               base_d = base_addr;
               len_d  = length;
               cnt_d  = {LEN_WIDTH{1'b0}};
`ifdef LOADER_VERIFY_EN
               wr_sum_d = {CHK_WIDTH{1'b0}};
               rd_sum_d = {CHK_WIDTH{1'b0}};
`endif
               if (length == {LEN_WIDTH{1'b0}}) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_LOAD;
                  s_ready_d = 1'b1;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_LOAD: begin
            if (beat_s) begin
               mem_addr_d = cur_addr_s;
               mem_din_d  = s_data;
               mem_we_d   = 1'b1;
`ifdef LOADER_VERIFY_EN
               wr_sum_d = wr_sum_q + CHK_WIDTH'(s_data);
`endif
               if (cnt_q == len_q - LEN_ONE) begin
                  cnt_d   = {LEN_WIDTH{1'b0}};
                  state_d = S_POST_LOAD;
               end else begin
                  cnt_d     = cnt_q + LEN_ONE;
                  s_ready_d = 1'b1;
               end
            end else if (s_ready_q) begin
               s_ready_d = 1'b1;
            end else begin
               // Last write has drained; without verify the core can be released now.
               state_d = S_DONE;
            end
         end
`ifdef LOADER_VERIFY_EN
         S_VERIFY: begin
            if (cnt_q != len_q) begin
               mem_addr_d = cur_addr_s;
               cnt_d      = cnt_q + LEN_ONE;
               rd_issue_d = 1'b1;
            end else begin
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            state_d = (wr_sum_q == rd_sum_next_s) ? S_DONE : S_ERROR;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d       = (state_d == S_LOAD) || (state_d == S_VERIFY) || (state_d == S_CHECK);
      done_d       = (state_d == S_DONE);
`ifdef LOADER_VERIFY_EN
      error_d      = (state_d == S_ERROR);
`else
      error_d      = 1'b0;
`endif
      core_rst_n_d = (state_d == S_DONE);
      mem_sel_d    = (state_d != S_DONE);
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         base_q       <= {ADDR_WIDTH{1'b0}};
         len_q        <= {LEN_WIDTH{1'b0}};
         cnt_q        <= {LEN_WIDTH{1'b0}};
         s_ready_q    <= 1'b0;
         mem_sel_q    <= 1'b1;
         mem_addr_q   <= {ADDR_WIDTH{1'b0}};
         mem_din_q    <= {DATA_WIDTH{1'b0}};
         mem_we_q     <= 1'b0;
         core_rst_n_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         s_ready_q    <= s_ready_d;
         mem_sel_q    <= mem_sel_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         mem_we_q     <= mem_we_d;
         core_rst_n_q <= core_rst_n_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

`ifdef LOADER_VERIFY_EN
   // Checksum accumulators and the read-return pipeline.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_sum_q   <= {CHK_WIDTH{1'b0}};
         rd_sum_q   <= {CHK_WIDTH{1'b0}};
         rd_issue_q <= 1'b0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_sum_q   <= wr_sum_d;
         rd_sum_q   <= rd_sum_d;
         rd_issue_q <= rd_issue_d;
         rd_valid_q <= rd_valid_d;
      end
   end
`endif

   assign s_ready      = s_ready_q;
   assign mem_sel      = mem_sel_q;
   assign mem_addr     = mem_addr_q;
   assign mem_din      = mem_din_q;
   assign mem_we       = mem_we_q;
   assign core_reset_n = core_rst_n_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: expected writes are queued as beats are accepted and popped as mem_we
// pulses appear; a synchronous memory model (optionally corrupting reads) backs the port.
`timescale 1ns/1ps
module tb_mem_loader;
`ifdef LOADER_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [15:0] base_addr;
   logic [16:0] length;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        mem_sel;
   logic [15:0] mem_addr;
   logic [7:0]  mem_din;
   logic        mem_we;
   logic [7:0]  mem_dout;
   logic        core_reset_n;
   logic        busy;
   logic        done;
   logic        error;

   int          cyc = 0;
   int          t0 = 0;
   int          errors = 0;
   int          checks = 0;
   int          we_count = 0;
   logic [23:0] exp_q[$];
   logic [7:0]  mem [0:65535];
   logic [7:0]  dout_r;
   logic        corrupt = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_loader dut (
      .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
      .core_reset_n(core_reset_n), .busy(busy), .done(done), .error(error)
   );

   always @(posedge clk) begin
      if (mem_we && mem_sel) mem[mem_addr] <= mem_din;
      dout_r <= mem[mem_addr];
   end
   assign mem_dout = dout_r ^ (corrupt ? 8'h01 : 8'h00);

   // Scoreboard: every write pulse must match the oldest accepted beat
   always @(negedge clk) begin
      if (reset_n && mem_we) begin
         logic [23:0] e;
         we_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", mem_addr, mem_din);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_din} !== e || mem_sel !== 1'b1) begin
               errors++;
               $display("FAIL write_scoreboard: got addr=%h data=%h sel=%b, expected addr=%h data=%h sel=1",
                        mem_addr, mem_din, mem_sel, e[23:8], e[7:0]);
            end
         end
      end
   end

   function automatic int done_lat(input int l);
      return VERIFY ? 2 * l + 3 : l + 2;
   endfunction

   task automatic do_start(input logic [15:0] b, input logic [16:0] l);
      @(posedge clk); #1;
      t0 = cyc;
      start = 1'b1; base_addr = b; length = l;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input logic [15:0] a);
      int n = 0;
      s_valid = 1'b1; s_data = w;
      while (!s_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!s_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: s_ready=%b after %0d cycles, expected 1", s_ready, n);
      end else begin
         exp_q.push_back({a, w});
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_end(output int lat);
      int n = 0;
      while (!(done || error) && n < 200) begin @(posedge clk); #1; n++; end
      lat = cyc - t0;
   endtask

   task automatic run_load(input logic [15:0] b, input int n, input logic [7:0] words [4],
                           input int stall_at, output int lat);
      logic [15:0] a;
      do_start(b, 17'(n));
      for (int i = 0; i < n; i++) begin
         if (i == stall_at) repeat (3) begin @(posedge clk); #1; end
         a = b + 16'(i);
         send_word(words[i], a);
      end
      wait_end(lat);
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; base_addr = 16'h0; length = 17'h0; s_valid = 1'b0; s_data = 8'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({s_ready, mem_sel, mem_we, core_reset_n, busy, done, error} !== 7'b0100000) begin
         errors++;
         $display("FAIL reset_ctrl: got rdy,sel,we,crst,busy,done,err=%b, expected 0100000",
                  {s_ready, mem_sel, mem_we, core_reset_n, busy, done, error});
      end
      checks++;
      if (mem_addr !== 16'h0 || mem_din !== 8'h0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h din=%h, expected 0000/00", mem_addr, mem_din);
      end
      @(negedge clk) reset_n = 1'b1;
   endtask

   task automatic test_basic;
      logic [7:0] w [4];
      int lat, wc0;
      w = '{8'hA9, 8'h05, 8'h85, 8'h10};
      wc0 = we_count;
      run_load(16'h8000, 4, w, -1, lat);
      checks++;
      if (lat !== done_lat(4)) begin
         errors++; $display("FAIL basic_done_edge: got %0d, expected %0d", lat, done_lat(4));
      end
      checks++;
      if ({done, error, core_reset_n, mem_sel, busy} !== 5'b10100) begin
         errors++;
         $display("FAIL basic_release: got done,err,crst,sel,busy=%b, expected 10100",
                  {done, error, core_reset_n, mem_sel, busy});
      end
      checks++;
      if (we_count - wc0 !== 4) begin
         errors++; $display("FAIL basic_write_count: got %0d, expected 4", we_count - wc0);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[16'h8000 + 16'(i)] !== w[i]) begin
            errors++; $display("FAIL basic_readback[%0d]: got %h, expected %h", i, mem[16'h8000 + 16'(i)], w[i]);
         end
      end
   endtask

   task automatic test_stall;
      logic [7:0] w [4];
      int lat, wc0;
      w = '{8'hA9, 8'h05, 8'h85, 8'h10};
      wc0 = we_count;
      run_load(16'h8000, 4, w, 2, lat);
      checks++;
      if (lat !== done_lat(4) + 3) begin
         errors++; $display("FAIL stall_done_edge: got %0d, expected %0d", lat, done_lat(4) + 3);
      end
      checks++;
      if (we_count - wc0 !== 4) begin
         errors++; $display("FAIL stall_write_count: got %0d, expected 4", we_count - wc0);
      end
   endtask

   task automatic test_corrupt;
      logic [7:0] w [4];
      int lat;
      w = '{8'hA9, 8'h05, 8'h85, 8'h10};
      corrupt = 1'b1;
      run_load(16'h4000, 4, w, -1, lat);
      corrupt = 1'b0;
      checks++;
      if ({error, done, core_reset_n} !== {VERIFY, !VERIFY, !VERIFY}) begin
         errors++;
         $display("FAIL corrupt_outcome: got err,done,crst=%b, expected %b",
                  {error, done, core_reset_n}, {VERIFY, !VERIFY, !VERIFY});
      end
      checks++;
      if (lat !== done_lat(4)) begin
         errors++; $display("FAIL corrupt_end_edge: got %0d, expected %0d", lat, done_lat(4));
      end
   endtask

   task automatic test_wrap;
      logic [7:0]  w [4];
      logic [15:0] addrs [4];
      int lat;
      w = '{8'h11, 8'h22, 8'h33, 8'h44};
      addrs = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      run_load(16'hFFFE, 4, w, -1, lat);
      checks++;
      if (done !== 1'b1 || lat !== done_lat(4)) begin
         errors++; $display("FAIL wrap_done: got done=%b at %0d, expected 1 at %0d", done, lat, done_lat(4));
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (mem[addrs[i]] !== w[i]) begin
            errors++; $display("FAIL wrap_readback[%h]: got %h, expected %h", addrs[i], mem[addrs[i]], w[i]);
         end
      end
   endtask

   task automatic test_zero_len;
      int wc0;
      wc0 = we_count;
      do_start(16'h1234, 17'h0);
      checks++;
      if ({done, busy, core_reset_n, mem_sel} !== 4'b1010) begin
         errors++;
         $display("FAIL zero_len_done: got done,busy,crst,sel=%b, expected 1010", {done, busy, core_reset_n, mem_sel});
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (we_count !== wc0) begin
         errors++; $display("FAIL zero_len_no_write: got %0d writes, expected 0", we_count - wc0);
      end
   endtask

   task automatic test_midreset;
      logic [7:0] w [4];
      int lat;
      w = '{8'h5A, 8'hC3, 8'h00, 8'h00};
      do_start(16'h1000, 17'd4);
      send_word(w[0], 16'h1000);
      send_word(w[1], 16'h1001);
      @(posedge clk); #1;
      reset_n = 1'b0;
      #2;
      checks++;
      if ({s_ready, mem_sel, mem_we, core_reset_n, busy, done, error} !== 7'b0100000 ||
          mem_addr !== 16'h0 || mem_din !== 8'h0) begin
         errors++;
         $display("FAIL midreset_outputs: got ctrl=%b addr=%h din=%h, expected 0100000/0000/00",
                  {s_ready, mem_sel, mem_we, core_reset_n, busy, done, error}, mem_addr, mem_din);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         errors++; $display("FAIL midreset_pending: got %0d unwritten beats, expected 0", exp_q.size());
      end
      @(negedge clk) reset_n = 1'b1;
      w = '{8'h77, 8'h88, 8'h00, 8'h00};
      run_load(16'h2000, 2, w, -1, lat);
      checks++;
      if (done !== 1'b1 || core_reset_n !== 1'b1 || lat !== done_lat(2)) begin
         errors++;
         $display("FAIL midreset_reload: got done=%b crst=%b at %0d, expected 1/1 at %0d", done, core_reset_n, lat, done_lat(2));
      end
      do_start(16'h2000, 17'd2);
      checks++;
      if (core_reset_n !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL restart_from_done: got crst=%b busy=%b done=%b, expected 0/1/0", core_reset_n, busy, done);
      end
      send_word(w[0], 16'h2000);
      send_word(w[1], 16'h2001);
      wait_end(lat);
      checks++;
      if (done !== 1'b1 || exp_q.size() !== 0) begin
         errors++; $display("FAIL restart_complete: got done=%b pending=%0d, expected 1/0", done, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_corrupt();
      test_zero_len();
      test_wrap();
      test_midreset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
